// File: rtl/wr_burst_gen_pkg.sv
// Shared definitions for the DDR write-burst generator: command codes, FSM states, bus widths.
package wr_burst_gen_pkg;

    localparam int unsigned ADDR_WIDTH     = 26;
    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned FIFO_CNT_WIDTH = 10;

    // Controller command codes, shared with the read-side generator
    typedef enum logic [2:0] {
        CmdNop   = 3'b000,
        CmdWrite = 3'b100,
        CmdRead  = 3'b110
    } cmd_e;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StWaitAck,
        StXfer,
        StBdone,
        StGap,
        StFinish
    } state_e;

endpackage

// File: rtl/wr_burst_gen.sv
// Write-burst generator: drains a FWFT sample FIFO into the DDR controller as a job of
// NUM_BURSTS fixed-length write bursts at consecutive addresses.
module wr_burst_gen
    import wr_burst_gen_pkg::*;
#(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    input  logic [CNT_W-1:0]          num_bursts,
    input  logic [DATA_WIDTH-1:0]     fifo_data,
    input  logic [FIFO_CNT_WIDTH-1:0] fifo_cnt,
    output logic                      fifo_rd,
    input  logic                      cmd_ack,
    input  logic                      data_ack,
    input  logic                      auto_ref_req,
    output logic                      write_out,
    output logic [2:0]                cmd_w,
    output logic [ADDR_WIDTH-1:0]     addr_w,
    output logic [DATA_WIDTH-1:0]     data_w,
    output logic                      burst_done_w,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned WC_W = $clog2(BURST_LEN);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
    logic [CNT_W-1:0]        rem_q, rem_d;
    logic [WC_W-1:0]         word_q, word_d;
    logic                    bd_second_q, bd_second_d;

    // Registered outputs: each _d is the value wanted in the state being entered
    logic                    write_out_q, write_out_d;
    cmd_e                    cmd_q, cmd_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    burst_done_q, burst_done_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    // Next-state, counter and registered-output logic
    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        rem_d        = rem_q;
        word_d       = word_q;
        bd_second_d  = 1'b0;
        write_out_d  = write_out_q;
        cmd_d        = CmdNop;
        addr_d       = addr_q;
        burst_done_d = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (num_bursts != '0) begin
                        cur_addr_d  = base_addr;
                        rem_d       = num_bursts;
                        word_d      = '0;
                        write_out_d = 1'b1;
                        busy_d      = 1'b1;
                        state_d     = StArm;
                    end else begin
                        // Empty job: acknowledge immediately without touching the controller
                        done_d = 1'b1;
                    end
                end
            end
            StArm: begin
                // Only start a burst the FIFO can fully feed, and never ahead of a refresh
                if (!auto_ref_req && (fifo_cnt >= FIFO_CNT_WIDTH'(BURST_LEN))) begin
                    cmd_d   = CmdWrite;
                    addr_d  = cur_addr_q;
                    state_d = StWaitAck;
                end
            end
            StWaitAck: begin
                cmd_d = CmdWrite;
                if (cmd_ack) begin
                    cmd_d   = CmdNop;
                    word_d  = '0;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (data_ack) begin
                    if (word_q == WC_W'(BURST_LEN - 1)) begin
                        word_d       = '0;
                        burst_done_d = 1'b1;
                        state_d      = StBdone;
                    end else begin
                        word_d = word_q + WC_W'(1);
                    end
                end
            end
            StBdone: begin
                if (!bd_second_q) begin
                    bd_second_d  = 1'b1;
                    burst_done_d = 1'b1;
                end else begin
                    rem_d      = rem_q - CNT_W'(1);
                    cur_addr_d = cur_addr_q + ADDR_WIDTH'(BURST_LEN);
                    if (rem_q != CNT_W'(1)) begin
                        state_d = StGap;
                    end else begin
                        write_out_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        state_d     = StFinish;
                    end
                end
            end
            StGap: begin
                // Let the controller drop its ack before the next command is raised
                if (!cmd_ack) begin
                    state_d = StArm;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, counters and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cur_addr_q   <= '0;
            rem_q        <= '0;
            word_q       <= '0;
            bd_second_q  <= 1'b0;
            write_out_q  <= 1'b0;
            cmd_q        <= CmdNop;
            addr_q       <= '0;
            burst_done_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            rem_q        <= rem_d;
            word_q       <= word_d;
            bd_second_q  <= bd_second_d;
            write_out_q  <= write_out_d;
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            burst_done_q <= burst_done_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // FWFT FIFO: the head word goes straight out and is popped on the same-cycle accept
    assign data_w       = fifo_data;
    assign fifo_rd      = (state_q == StXfer) && data_ack && !rst;
    assign write_out    = write_out_q;
    assign cmd_w        = cmd_q;
    assign addr_w       = addr_q;
    assign burst_done_w = burst_done_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_wr_burst_gen.sv
// Self-checking bench for wr_burst_gen: a scripted job model predicts every output each cycle,
// and per-job literal expectations pin the model on the directed scenarios.
module tb_wr_burst_gen;

    localparam int BL = 4;

    logic        clk = 1'b0;
    logic        rst, start, cmd_ack, data_ack, auto_ref_req;
    logic [25:0] base_addr;
    logic [15:0] num_bursts;
    logic [31:0] fifo_data;
    logic [9:0]  fifo_cnt;
    logic        fifo_rd, write_out, burst_done_w, busy, done;
    logic [2:0]  cmd_w;
    logic [25:0] addr_w;
    logic [31:0] data_w;

    wr_burst_gen #(.BURST_LEN(BL), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_bursts(num_bursts), .fifo_data(fifo_data), .fifo_cnt(fifo_cnt),
        .fifo_rd(fifo_rd), .cmd_ack(cmd_ack), .data_ack(data_ack),
        .auto_ref_req(auto_ref_req), .write_out(write_out), .cmd_w(cmd_w),
        .addr_w(addr_w), .data_w(data_w), .burst_done_w(burst_done_w),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Expected outputs for the current cycle, written by the script
    logic        e_wo, e_busy, e_bd, e_done, e_rd, e_addr_vld;
    logic [2:0]  e_cmd;
    logic [25:0] e_addr;
    bit          chk_en = 1'b0;
    int          job_id = 0, pin_id = 0, pin_kind = 0, prev_kind = 0;

    // Checker-owned state
    int          total = 0, bad = 0;
    int          pops = 0, dones = 0, wo_cyc = 0, wo_drop = 0;
    int          pops_b = 0, dones_b = 0, wo_cyc_b = 0, wo_drop_b = 0, addr_b = 0;
    int          cur_job = 0, done_pin = 0;
    logic [25:0] addrs[$];
    logic [2:0]  prev_cmd = 3'b000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] get_addr(input int k);
        if (addr_b + k < addrs.size()) return {6'd0, addrs[addr_b + k]};
        return 32'hFFFF_FFFF;
    endfunction

    task automatic pin_checks(input int kind);
        int dp, na, dd;
        dp = pops - pops_b;
        na = addrs.size() - addr_b;
        dd = dones - dones_b;
        case (kind)
            1: begin
                chk("single_pops", dp, 4);
                chk("single_bursts", na, 1);
                chk("single_addr", get_addr(0), 32'h100);
                chk("single_done", dd, 1);
            end
            2: begin
                chk("wrap_pops", dp, 12);
                chk("wrap_bursts", na, 3);
                chk("wrap_addr0", get_addr(0), 32'h3FF_FFF8);
                chk("wrap_addr1", get_addr(1), 32'h3FF_FFFC);
                chk("wrap_addr2", get_addr(2), 32'h000_0000);
                chk("wrap_wo_drop", wo_drop - wo_drop_b, 0);
                chk("wrap_done", dd, 1);
            end
            3: begin
                chk("zero_pops", dp, 0);
                chk("zero_bursts", na, 0);
                chk("zero_wo_cycles", wo_cyc - wo_cyc_b, 0);
                chk("zero_done", dd, 1);
            end
            4: begin
                chk("abort_pops", dp, 2);
                chk("abort_bursts", na, 1);
                chk("abort_addr", get_addr(0), 32'h500);
                chk("abort_done", dd, 0);
            end
            5: begin
                chk("busy_start_bursts", na, 2);
                chk("busy_start_addr0", get_addr(0), 32'h2000);
                chk("busy_start_addr1", get_addr(1), 32'h2004);
                chk("busy_start_pops", dp, 8);
                chk("busy_start_done", dd, 1);
            end
            6: begin
                chk("post_rst_pops", dp, 4);
                chk("post_rst_addr", get_addr(0), 32'h600);
                chk("post_rst_done", dd, 1);
            end
            default: ;
        endcase
    endtask

    // Compare process: every cycle, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (pin_id != done_pin) begin
                    done_pin = pin_id;
                    pin_checks(pin_kind);
                end
                if (job_id != cur_job) begin
                    cur_job   = job_id;
                    pops_b    = pops;
                    dones_b   = dones;
                    wo_cyc_b  = wo_cyc;
                    wo_drop_b = wo_drop;
                    addr_b    = addrs.size();
                end
                chk("write_out", 32'(write_out), 32'(e_wo));
                chk("busy", 32'(busy), 32'(e_busy));
                chk("cmd_w", 32'(cmd_w), 32'(e_cmd));
                chk("burst_done_w", 32'(burst_done_w), 32'(e_bd));
                chk("done", 32'(done), 32'(e_done));
                chk("fifo_rd", 32'(fifo_rd), 32'(e_rd));
                chk("data_w", data_w, fifo_data);
                if (e_addr_vld) chk("addr_w", 32'(addr_w), 32'(e_addr));
                if (cmd_w == 3'b100 && prev_cmd != 3'b100) addrs.push_back(addr_w);
                prev_cmd = cmd_w;
                pops    += int'(fifo_rd);
                dones   += int'(done);
                wo_cyc  += int'(write_out);
                wo_drop += int'(busy && !write_out);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs the DUT must ignore in the current phase get random values
    task automatic rand_dc();
        rst          = 1'b0;
        start        = 1'b0;
        base_addr    = 26'($urandom);
        num_bursts   = 16'($urandom);
        fifo_data    = $urandom;
        fifo_cnt     = 10'($urandom);
        cmd_ack      = 1'($urandom);
        data_ack     = 1'($urandom);
        auto_ref_req = 1'($urandom);
    endtask

    task automatic idle_exp();
        e_wo = 1'b0; e_busy = 1'b0; e_cmd = 3'b000; e_bd = 1'b0;
        e_done = 1'b0; e_rd = 1'b0; e_addr_vld = 1'b0; e_addr = '0;
    endtask

    task automatic busy_exp(input bit spur, input bit rnd);
        e_wo = 1'b1; e_busy = 1'b1; e_cmd = 3'b000; e_bd = 1'b0;
        e_done = 1'b0; e_rd = 1'b0; e_addr_vld = 1'b0;
        start = spur | (rnd && $urandom_range(0, 3) == 0);
        if (spur) begin
            base_addr  = 26'h300_0000;
            num_bursts = 16'd7;
        end
    endtask

    // One job, described phase by phase from the protocol rules
    task automatic do_job(input logic [25:0] base, input logic [15:0] n, input int gate_mode,
                          input bit rnd, input bit abort2, input bit spur, input int kind,
                          input bit after_rst);
        logic [25:0] ba;
        int blk, d, h, words, xc;
        rand_dc(); idle_exp();
        start = 1'b1; base_addr = base; num_bursts = n;
        e_addr_vld = after_rst;
        pin_kind = prev_kind; pin_id++; job_id++; prev_kind = kind;
        tick();
        if (n == 16'd0) begin
            rand_dc(); idle_exp(); e_done = 1'b1;
            tick();
            return;
        end
        for (int b = 0; b < int'(n); b++) begin
            ba = base + 26'(b * BL);
            blk = (gate_mode == 1) ? int'($urandom_range(0, 3)) :
                  (gate_mode == 2 && b == 0) ? 6 : 0;
            for (int i = 0; i < blk; i++) begin
                rand_dc(); busy_exp(spur, rnd);
                if (gate_mode == 2) begin
                    auto_ref_req = (i >= 3);
                    fifo_cnt     = (i < 3) ? 10'd3 : 10'd4;
                end else if ($urandom_range(0, 1) == 1) begin
                    auto_ref_req = 1'b1;
                end else begin
                    auto_ref_req = 1'b0;
                    fifo_cnt     = 10'($urandom_range(0, BL - 1));
                end
                tick();
            end
            rand_dc(); busy_exp(spur, rnd);
            auto_ref_req = 1'b0;
            fifo_cnt = (gate_mode == 2) ? 10'(BL) : rnd ? 10'($urandom_range(BL, 1023)) : 10'd8;
            tick();
            d = rnd ? int'($urandom_range(0, 3)) : 3;
            for (int i = 0; i <= d; i++) begin
                rand_dc(); busy_exp(spur, rnd);
                e_cmd = 3'b100; e_addr_vld = 1'b1; e_addr = ba;
                cmd_ack = (i == d);
                tick();
            end
            words = 0;
            xc = 0;
            while (words < BL) begin
                rand_dc(); busy_exp(spur, rnd);
                data_ack = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (xc >= 12) data_ack = 1'b1;
                xc++;
                if (abort2 && words == 2) begin
                    rst = 1'b1; data_ack = 1'b0;
                    tick();
                    return;
                end
                e_rd = data_ack;
                if (data_ack) words++;
                tick();
            end
            for (int i = 0; i < 2; i++) begin
                rand_dc(); busy_exp(spur, rnd); e_bd = 1'b1;
                tick();
            end
            if (b < int'(n) - 1) begin
                h = rnd ? int'($urandom_range(0, 2)) : 0;
                for (int i = 0; i <= h; i++) begin
                    rand_dc(); busy_exp(spur, rnd);
                    cmd_ack = (i < h);
                    tick();
                end
            end
        end
        rand_dc(); idle_exp(); e_done = 1'b1;
        tick();
    endtask

    initial begin
        logic [25:0] rb;
        rand_dc(); idle_exp(); rst = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            rand_dc(); idle_exp(); rst = 1'b1; e_addr_vld = 1'b1;
            chk_en = 1'b1;
            tick();
        end
        do_job(26'h100, 16'd1, 0, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        do_job(26'h3FF_FFF8, 16'd3, 1, 1'b1, 1'b0, 1'b0, 2, 1'b0);
        do_job(26'h123, 16'd0, 0, 1'b0, 1'b0, 1'b0, 3, 1'b0);
        do_job(26'h40, 16'd1, 2, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        do_job(26'h500, 16'd2, 0, 1'b0, 1'b1, 1'b0, 4, 1'b0);
        do_job(26'h600, 16'd1, 0, 1'b0, 1'b0, 1'b0, 6, 1'b1);
        do_job(26'h2000, 16'd2, 0, 1'b0, 1'b0, 1'b1, 5, 1'b0);
        for (int j = 0; j < 30; j++) begin
            rb = ($urandom_range(0, 2) == 0) ? (26'h3FF_FFF0 | 26'($urandom_range(0, 15)))
                                             : 26'($urandom);
            do_job(rb, 16'($urandom_range(0, 4)), 1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        end
        rand_dc(); idle_exp();
        pin_kind = prev_kind; pin_id++;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wr_burst_gen.md
WR_BURST_GEN -- requirements
Module: WR_BURST_GEN

Interface
REQ-001 Parameter BURST_LEN, default 4: number of 32-bit words per write burst; legal values are 2, 4 and 8.
REQ-002 Parameter CNT_W, default 16: width of NUM_BURSTS and of the internal burst counter.
REQ-003 Port CLK, in, 1: the single clock; all logic is rising-edge.
REQ-004 Port RST, in, 1: reset; synchronous and active-high.
REQ-005 Port START, in, 1: one-cycle request to begin a write job.
REQ-006 Port BASE_ADDR, in, 26: first word address of the job.
REQ-007 Port NUM_BURSTS, in, CNT_W: number of bursts in the job.
REQ-008 Port FIFO_DATA, in, 32: head word of the sample FIFO, which is first-word-fall-through.
REQ-009 Port FIFO_CNT, in, 10: number of words currently held in the sample FIFO.
REQ-010 Port FIFO_RD, out, 1: pops one FIFO word.
REQ-011 Port CMD_ACK, in, 1: controller command acknowledge.
REQ-012 Port DATA_ACK, in, 1: controller accepts DATA_W on this cycle.
REQ-013 Port AUTO_REF_REQ, in, 1: controller refresh pending.
REQ-014 Port WRITE_OUT, out, 1: write-path select; drives WRITE_IN of the RW selector.
REQ-015 Port CMD_W, out, 3: write command; drives CMD_IN_W.
REQ-016 Port ADDR_W, out, 26: burst start address; drives ADDR_IN_W.
REQ-017 Port DATA_W, out, 32: write data; drives DATA_IN_W.
REQ-018 Port BURST_DONE_W, out, 1: burst terminate; drives BURST_DONE_W.
REQ-019 Port BUSY, out, 1: a job is in progress.
REQ-020 Port DONE, out, 1: one-cycle pulse at job end.

Function
REQ-021 The FSM SHALL have the states IDLE, ARM, WAIT_ACK, XFER, BDONE, GAP and FINISH.
REQ-022 In IDLE, START with NUM_BURSTS != 0 SHALL latch BASE_ADDR and NUM_BURSTS, set BUSY=1 and WRITE_OUT=1, and move to ARM on the next edge.
REQ-023 In IDLE, START with NUM_BURSTS == 0 SHALL produce DONE=1 on the next cycle, with no WRITE_OUT and no command issued.
REQ-024 START SHALL be ignored whenever BUSY=1.
REQ-025 ARM SHALL move to WAIT_ACK only when AUTO_REF_REQ=0 and FIFO_CNT >= BURST_LEN; otherwise it holds with CMD_W=000.
REQ-026 In WAIT_ACK, CMD_W SHALL be 100 (write) and ADDR_W the current burst address; CMD_ACK=1 moves the FSM to XFER.
REQ-027 In XFER:
- DATA_W SHALL equal FIFO_DATA.
- FIFO_RD SHALL equal DATA_ACK, in the same cycle.
- Each DATA_ACK SHALL increment the word counter.
- When the BURST_LEN-th word is acknowledged, the FSM moves to BDONE.
REQ-028 DATA_ACK outside XFER SHALL NOT pop the FIFO.
REQ-029 BDONE SHALL hold BURST_DONE_W=1 for exactly 2 cycles, with CMD_W=000.
- It then decrements the remaining-burst count and adds BURST_LEN to the address, modulo 2^26 (wrap from 0x3FFFFFC to 0x0000000 when BURST_LEN=4).
REQ-030 At BDONE exit, if remaining bursts > 0 the FSM SHALL go to GAP, otherwise to FINISH.
REQ-031 GAP SHALL wait until CMD_ACK=0, then go to ARM.
REQ-032 FINISH SHALL set WRITE_OUT=0, BUSY=0 and DONE=1 for one cycle, then return to IDLE.
REQ-033 WRITE_OUT SHALL stay at 1 continuously from ARM through the end of the final BDONE.
REQ-034 AUTO_REF_REQ SHALL affect only the ARM gate and SHALL NOT interrupt a burst already in WAIT_ACK, XFER or BDONE.
REQ-035 FIFO_CNT is checked only in ARM; mid-burst underflow is excluded by design.
REQ-036 All outputs except DATA_W and FIFO_RD SHALL be registered.

Reset
REQ-037 While RST=1 at a rising edge, the block SHALL:
- enter IDLE and clear all counters;
- drive FIFO_RD=0, WRITE_OUT=0, CMD_W=000, ADDR_W=0, BURST_DONE_W=0, BUSY=0, DONE=0;
- drive DATA_W=FIFO_DATA (pass-through).
REQ-038 RST asserted mid-job SHALL abandon the job with no DONE pulse, and the block SHALL accept START on the first cycle after RST falls.

Structure
REQ-039 The command codes (NOP=000, WRITE=100, READ=110) and the FSM state encodings SHALL reside in the shared include ddr_defs.vh, also used by the read-side generator.
REQ-040 The block SHALL be a single module with no sub-module; the counters and the address adder are inline.

Verification
REQ-041 Single burst: BASE_ADDR=0x100, NUM_BURSTS=1, FIFO_CNT=8, CMD_ACK after 3 cycles, DATA_ACK for 4 consecutive cycles -> CMD_W=100 at ADDR 0x100; 4 FIFO_RD pulses; BURST_DONE_W for 2 cycles; DONE one cycle later.
REQ-042 Three bursts: BASE_ADDR=0x3FFFFF8, NUM_BURSTS=3 -> ADDR_W sequence 0x3FFFFF8, 0x3FFFFFC, 0x0000000; 12 pops; WRITE_OUT never drops mid-job.
REQ-043 Gating: FIFO_CNT=3, then AUTO_REF_REQ=1 with FIFO_CNT=4 -> FSM held in ARM with CMD_W=000; the command issues on the cycle after both conditions clear.
REQ-044 Zero job: NUM_BURSTS=0 -> DONE pulse on the next cycle; WRITE_OUT, CMD_W and FIFO_RD all stay 0.
REQ-045 Reset mid-XFER after 2 words -> all outputs at reset values on the next edge; no DONE; a new START after reset completes normally.
REQ-046 START while BUSY, with a different BASE_ADDR -> ignored; the original job's addresses are used.
